// File: rtl/npu_pkg.sv
// Shared NPU definitions: FC1 layer geometry and the weight-stream sequencer states.
package npu_pkg;

    // Sequencer states, visible on the debug port of fc1_wstream_sched.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } fc1s_state_e;

    // Processing elements in the FCN; one signed weight byte per PE per group.
    localparam int NUM_PE = 4;

    // FC1 layer shape.
    localparam int IN1_N  = 132;
    localparam int OUT1_M = 10;

    // Weight groups streamed per inference.
    localparam int FC1_N_WORDS = IN1_N * OUT1_M / NUM_PE;

    // Weight SRAM word-address width and group counter width (2^CNT_W > N_WORDS).
    localparam int FC1_ADDR_W = 12;
    localparam int FC1_CNT_W  = 9;

endpackage

// File: rtl/fc1_wstream_sched_if.sv
// Bus bundle of the FC1 weight streamer: weight SRAM read port plus the
// fc1_w group stream into the FCN.
//
// Handshake: w_valid/w_ready is a strict valid/ready pair. A group moves on
// every rising edge where both are high. Once w_valid rises it stays high and
// w_data stays stable until that transfer happens, except that an abort may
// withdraw w_valid. The SRAM port has no handshake: mem_rdata is valid the
// cycle after mem_re.
interface fc1_wstream_sched_if #(
    parameter int ADDR_W = 12,
    parameter int NUM_PE = 4
);
    logic                  mem_re;
    logic [ADDR_W-1:0]     mem_addr;
    logic [8*NUM_PE-1:0]   mem_rdata;
    logic [8*NUM_PE-1:0]   w_data;
    logic                  w_valid;
    logic                  w_ready;

    // Sequencer side: drives SRAM reads and the group stream.
    modport master (
        output mem_re, mem_addr, w_data, w_valid,
        input  mem_rdata, w_ready
    );

    // SRAM/FCN side.
    modport slave (
        input  mem_re, mem_addr, w_data, w_valid,
        output mem_rdata, w_ready
    );
endinterface

// File: rtl/wstream_fifo.sv
// Two-entry synchronous FIFO with a registered head entry. The head register
// drives w_data directly, so the group stays stable while the consumer stalls.
module wstream_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] tail_q;

    // Head/tail entries and occupancy; flush empties the buffer without touching data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail_q <= '0;
            count  <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail_q <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head   <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    // Credit accounting upstream must never let a push land on a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && count == 2'd2));

    // Popping an empty buffer would mean w_valid was wrong.
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && !flush && count == 2'd0));

endmodule

// File: rtl/fc1_wstream_sched.sv
// FC1 weight-stream sequencer: reads N_WORDS consecutive SRAM words starting
// at base_addr and presents them as groups on the fc1_w stream, prefetching
// through a 2-entry buffer so the stream can move one group per cycle.
module fc1_wstream_sched
    import npu_pkg::*;
#(
    parameter int ADDR_W  = FC1_ADDR_W,
    parameter int N_WORDS = FC1_N_WORDS,
    parameter int CNT_W   = FC1_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    fc1_wstream_sched_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     words_sent,
    output fc1s_state_e          dbg_state
);

    fc1s_state_e          state_q, state_d;
    logic [ADDR_W-1:0]    base_q;
    logic [CNT_W-1:0]     issued_q;
    logic [CNT_W-1:0]     sent_q;
    logic                 inflight_q;
    logic [1:0]           fifo_count;
    logic                 mem_re;
    logic                 start_acc;
    logic                 abort_acc;
    logic                 pop;
    logic                 push;
    logic                 flush;
    logic                 last_xfer;
    logic                 read_ok;
    logic [2:0]           credit_used;

    // abort beats start in IDLE; abort only matters once a stream exists.
    assign start_acc = (state_q == IDLE) && start && !abort;
    assign abort_acc = (state_q != IDLE) && abort;

    assign pop       = bus.w_valid && bus.w_ready;
    assign push      = inflight_q && (state_q == STREAM) && !abort_acc;
    assign flush     = start_acc || abort_acc;
    assign last_xfer = pop && (sent_q == CNT_W'(N_WORDS - 1));

    // Slots already claimed after this cycle's pop: buffered plus returning data.
    assign credit_used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign read_ok     = (issued_q < CNT_W'(N_WORDS)) && (credit_used < 3'd2);

    assign bus.mem_re   = mem_re;
    assign bus.mem_addr = base_q + ADDR_W'(issued_q);
    assign bus.w_valid  = (fifo_count != 2'd0);
    assign words_sent   = sent_q;
    assign dbg_state    = state_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d = state_q;
        mem_re  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_acc) state_d = STREAM;
            end
            STREAM: begin
                busy   = 1'b1;
                mem_re = read_ok && !abort;
                if (abort)          state_d = IDLE;
                else if (last_xfer) state_d = FINISH;
            end
            FINISH: begin
                busy    = 1'b1;
                done    = !abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream counters, latched base address and the in-flight read flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= mem_re;
            if (start_acc) begin
                base_q   <= base_addr;
                issued_q <= '0;
                sent_q   <= '0;
            end else begin
                if (mem_re)                      issued_q <= issued_q + 1'b1;
                if (pop && (state_q == STREAM))  sent_q   <= sent_q + 1'b1;
            end
        end
    end

    wstream_fifo #(.W(8 * NUM_PE)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.mem_rdata),
        .head  (bus.w_data),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fc1_wstream_sched.sv
// Bench for fc1_wstream_sched: SRAM model, directed streams, and a negedge
// scoreboard holding the expected group and address sequences of a stream.
module tb_fc1_wstream_sched;
    import npu_pkg::*;

    localparam int AW = FC1_ADDR_W;
    localparam int DW = 8 * NUM_PE;
    localparam int N  = FC1_N_WORDS;
    localparam int CW = FC1_CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic           busy, done;
    logic [CW-1:0]  words_sent;
    fc1s_state_e    dbg_state;

    fc1_wstream_sched_if #(.ADDR_W(AW), .NUM_PE(NUM_PE)) bus ();

    fc1_wstream_sched #(.ADDR_W(AW), .N_WORDS(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent),
        .dbg_state  (dbg_state)
    );

    // ---------------- SRAM model ----------------
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {NUM_PE{a[7:0]}};
    endfunction

    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= word(bus.mem_addr);
        else            bus.mem_rdata <= DW'($urandom);
    end

    // 0: ready high, 1: random 50%, 2: ready low
    int rdy_mode = 0;
    initial bus.w_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.w_ready = 1'b1;
            1:       bus.w_ready = 1'($urandom_range(0, 1));
            default: bus.w_ready = 1'b0;
        endcase
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0]  exp_q[$];
    logic [AW-1:0]  addr_q[$];
    bit             m_busy = 1'b0;
    bit             m_fin  = 1'b0;
    int             m_sent = 0;
    int             m_rd   = 0;
    int             done_cnt = 0;
    bit             prev_stall = 1'b0;
    logic [DW-1:0]  prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            m_busy = 1'b0;
            m_fin = 1'b0;
            m_sent = 0;
            m_rd = 0;
            prev_stall = 1'b0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_fin && !abort);
            chk("words_sent", words_sent, m_sent);
            if (!m_busy || m_fin) begin
                chk("w_valid_quiet", bus.w_valid, 1'b0);
                chk("mem_re_quiet", bus.mem_re, 1'b0);
            end
            if (bus.w_valid) begin
                if (exp_q.size() == 0) chk("w_valid_extra", 1'b1, 1'b0);
                else                   chk("w_data", bus.w_data, exp_q[0]);
                if (prev_stall) chk("w_data_hold", bus.w_data, prev_data);
            end
            if (bus.mem_re) begin
                if (addr_q.size() == 0) chk("mem_re_extra", 1'b1, 1'b0);
                else                    chk("mem_addr", bus.mem_addr, addr_q.pop_front());
                m_rd++;
            end
            if (bus.w_valid && bus.w_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                m_sent++;
            end
            if (m_busy && !m_fin) chk("reads_ahead_le2", (m_rd - m_sent) <= 2, 1'b1);
            prev_stall = bus.w_valid && !bus.w_ready;
            prev_data  = bus.w_data;
            if (done) done_cnt++;

            // advance the model by this cycle's controls
            if (!m_busy) begin
                if (start && !abort) begin
                    m_busy = 1'b1;
                    m_sent = 0;
                    m_rd = 0;
                    exp_q.delete();
                    addr_q.delete();
                    for (int k = 0; k < N; k++) begin
                        addr_q.push_back(AW'(base_addr + k));
                        exp_q.push_back(word(AW'(base_addr + k)));
                    end
                end
            end else if (abort) begin
                m_busy = 1'b0;
                m_fin = 1'b0;
                exp_q.delete();
                addr_q.delete();
                prev_stall = 1'b0;
            end else if (m_fin) begin
                m_busy = 1'b0;
                m_fin = 1'b0;
            end else if (m_sent == N) begin
                m_fin = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic at_cycle(input int c);
        forever begin
            @(negedge clk);
            if (cyc >= c) break;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, output int t);
        base_addr = b;
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_re"}, bus.mem_re, 1'b0);
        chk({tag, "_mem_addr"}, bus.mem_addr, '0);
        chk({tag, "_w_valid"}, bus.w_valid, 1'b0);
        chk({tag, "_w_data"}, bus.w_data, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_words_sent"}, words_sent, '0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    // Full stream with ready held high; exact cycle timing plus two literal groups.
    task automatic basic_stream(input logic [AW-1:0] b, input string tag,
                                input logic [DW-1:0] g0, input logic [DW-1:0] g5);
        int t, vcnt, d0;
        rdy_mode = 0;
        d0 = done_cnt;
        pulse_start(b, t);
        at_cycle(t + 1);
        chk({tag, "_busy_T1"}, busy, 1'b1);
        chk({tag, "_mem_re_T1"}, bus.mem_re, 1'b1);
        chk({tag, "_mem_addr_T1"}, bus.mem_addr, b);
        at_cycle(t + 2);
        chk({tag, "_w_valid_T2"}, bus.w_valid, 1'b0);
        vcnt = 0;
        for (int c = t + 3; c <= t + N + 2; c++) begin
            at_cycle(c);
            if (bus.w_valid && bus.w_ready) vcnt++;
            if (c == t + 3) chk({tag, "_group0"}, bus.w_data, g0);
            if (c == t + 8) chk({tag, "_group5"}, bus.w_data, g5);
        end
        chk({tag, "_consecutive_xfers"}, vcnt, N);
        at_cycle(t + N + 3);
        chk({tag, "_done_cycle"}, done, 1'b1);
        at_cycle(t + N + 4);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_words_final"}, words_sent, 330);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t, d0;
        bit vseen;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;
        tick();

        // basic stream
        basic_stream(12'h100, "basic", 32'h00000000, 32'h05050505);
        tick();

        // backpressure
        d0 = done_cnt;
        rdy_mode = 1;
        pulse_start(12'h3C0, t);
        wait_idle(4000);
        chk("bp_words_final", words_sent, 330);
        chk("bp_done_once", done_cnt - d0, 1);
        rdy_mode = 0;
        tick();

        // address wrap
        pulse_start(12'hFF0, t);
        at_cycle(t + 1);
        chk("wrap_first_addr", bus.mem_addr, 12'hFF0);
        at_cycle(t + 17);
        chk("wrap_addr_zero", bus.mem_addr, 12'h000);
        at_cycle(t + 330);
        chk("wrap_last_re", bus.mem_re, 1'b1);
        chk("wrap_last_addr", bus.mem_addr, 12'h139);
        at_cycle(t + 331);
        chk("wrap_no_more_reads", bus.mem_re, 1'b0);
        wait_idle(1000);
        tick();

        // abort after 17 transfers with a read in flight
        d0 = done_cnt;
        pulse_start(12'h040, t);
        at_cycle(t + 19);
        chk("abort_read_before", bus.mem_re, 1'b1);
        goto_cycle(t + 20);
        rdy_mode = 2;
        abort = 1'b1;
        at_cycle(t + 20);
        chk("abort_sent_before", words_sent, 17);
        goto_cycle(t + 21);
        abort = 1'b0;
        at_cycle(t + 21);
        chk("abort_w_valid", bus.w_valid, 1'b0);
        chk("abort_mem_re", bus.mem_re, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_words", words_sent, 17);
        vseen = 1'b0;
        rdy_mode = 0;
        for (int c = t + 22; c < t + 32; c++) begin
            at_cycle(c);
            vseen |= bus.w_valid | done;
        end
        chk("abort_quiet_after", vseen, 1'b0);
        chk("abort_no_done", done_cnt - d0, 0);
        tick();
        basic_stream(12'h040, "restart", 32'h40404040, 32'h45454545);
        tick();

        // start and abort together in IDLE
        base_addr = 12'h555;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        at_cycle(cyc);
        chk("startabort_busy", busy, 1'b0);
        chk("startabort_mem_re", bus.mem_re, 1'b0);
        tick();

        // start while busy is ignored
        d0 = done_cnt;
        pulse_start(12'h200, t);
        goto_cycle(t + 50);
        base_addr = 12'h300;
        start = 1'b1;
        tick();
        start = 1'b0;
        at_cycle(t + 51);
        chk("rebusy_mem_re", bus.mem_re, 1'b1);
        chk("rebusy_mem_addr", bus.mem_addr, 12'h232);
        wait_idle(1000);
        chk("rebusy_words_final", words_sent, 330);
        chk("rebusy_done_once", done_cnt - d0, 1);
        tick();

        // reset mid-stream at transfer 100
        pulse_start(12'h100, t);
        at_cycle(t + 103);
        chk("rstmid_words_before", words_sent, 100);
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("rstmid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        basic_stream(12'h100, "post_rst", 32'h00000000, 32'h05050505);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

endmodule
